// File: rtl/cam_pkg.sv
// cam_pkg: shared FSM type, default frame geometry and RGB565 field widths for the DVP capture path
package cam_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_VBLANK, S_ACTIVE} cam_state_t;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int R_W = 5;
  localparam int G_W = 6;
  localparam int B_W = 5;
  localparam int PIX_W = R_W + G_W + B_W;
  localparam int BYTE_W = PIX_W / 2;
endpackage

// File: rtl/cam_sync_edge.sv
// cam_sync_edge: multi-flop synchronizer with optional rising/falling edge detection
module cam_sync_edge #(
  parameter int W = 1,
  parameter int STAGES = 2,
  parameter bit EDGE = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);
  logic [W-1:0] sync [STAGES];
  // shift the asynchronous input through the synchronizer chain
  always_ff @(posedge clk)
    if (reset) for (int i = 0; i < STAGES; i++) sync[i] <= '0;
    else begin
      sync[0] <= d;
      for (int i = 1; i < STAGES; i++) sync[i] <= sync[i-1];
    end
  assign q = sync[STAGES-1];
  if (EDGE) begin : g_edge
    logic [W-1:0] prev;
    // one further register holds the previous synchronized value
    always_ff @(posedge clk) prev <= reset ? '0 : q;
    assign rise = q & ~prev;
    assign fall = ~q & prev;
  end else begin : g_data
    assign rise = '0;
    assign fall = '0;
  end
endmodule

// File: rtl/cam_dvp_capture.sv
// cam_dvp_capture: samples a DVP camera bus and emits RGB565 pixels as a valid/ready stream with coordinates
module cam_dvp_capture import cam_pkg::*; #(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int SYNC_STAGES = 2,
  parameter bit VSYNC_POL = 1'b1,
  localparam int XW = $clog2(H_ACTIVE),
  localparam int YW = $clog2(V_ACTIVE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear_err,
  input  logic              cam_pclk,
  input  logic              cam_href,
  input  logic              cam_vsync,
  input  logic [BYTE_W-1:0] cam_d,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [XW-1:0]     pix_x,
  output logic [YW-1:0]     pix_y,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              frame_done,
  output logic [7:0]        frame_cnt,
  output logic              overflow,
  output logic              line_err
);
  localparam int XCW = $clog2(H_ACTIVE + 2);
  localparam int YCW = $clog2(V_ACTIVE + 1);
  localparam logic [XCW-1:0] H_MAX = XCW'(H_ACTIVE);
  localparam logic [XCW-1:0] H_LAST = XCW'(H_ACTIVE - 1);
  localparam logic [YCW-1:0] Y_MAX = YCW'(V_ACTIVE);
  cam_state_t state;
  logic [XCW-1:0] x;
  logic [YCW-1:0] y;
  logic phase;
  logic [BYTE_W-1:0] hi, d_q, d_rise, d_fall;
  logic pclk_q, pclk_rise, pclk_fall, href_q, href_rise, href_fall, vs_q, vs_rise, vs_fall;
  logic vs_act, vs_on, active, cap, pix_done, line_end, load, ov_set, le_set;
  logic unused_ok;
  cam_sync_edge #(.W(1), .STAGES(SYNC_STAGES)) u_pclk (
    .clk(clk), .reset(reset), .d(cam_pclk), .q(pclk_q), .rise(pclk_rise), .fall(pclk_fall)
  );
  cam_sync_edge #(.W(1), .STAGES(SYNC_STAGES)) u_href (
    .clk(clk), .reset(reset), .d(cam_href), .q(href_q), .rise(href_rise), .fall(href_fall)
  );
  cam_sync_edge #(.W(1), .STAGES(SYNC_STAGES)) u_vsync (
    .clk(clk), .reset(reset), .d(cam_vsync), .q(vs_q), .rise(vs_rise), .fall(vs_fall)
  );
  cam_sync_edge #(.W(BYTE_W), .STAGES(SYNC_STAGES), .EDGE(1'b0)) u_data (
    .clk(clk), .reset(reset), .d(cam_d), .q(d_q), .rise(d_rise), .fall(d_fall)
  );
  assign unused_ok = ^{pclk_q, pclk_fall, href_rise, d_rise, d_fall};
  // decode capture, line-end and frame-end events; vsync_on takes priority over pixel and line events
  always_comb begin
    vs_act = VSYNC_POL ? vs_q : ~vs_q;
    vs_on = VSYNC_POL ? vs_rise : vs_fall;
    active = state == S_ACTIVE;
    cap = active && !vs_on && pclk_rise && href_q;
    pix_done = cap && phase && x < H_MAX && y < Y_MAX;
    line_end = active && !vs_on && href_fall;
    load = pix_done && (!pix_valid || pix_ready);
    ov_set = pix_done && pix_valid && !pix_ready;
    le_set = (line_end && y < Y_MAX && (x != H_MAX || phase)) || (active && vs_on && href_q);
  end
  // frame FSM plus byte phase and x/y position tracking
  always_ff @(posedge clk)
    if (reset) begin
      state <= S_IDLE;
      x <= '0;
      y <= '0;
      phase <= 1'b0;
      hi <= '0;
      frame_done <= 1'b0;
      frame_cnt <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: if (enable) state <= S_SYNC;
        S_SYNC: if (vs_act) state <= S_VBLANK;
        S_VBLANK:
          if (!vs_act) begin
            state <= enable ? S_ACTIVE : S_IDLE;
            x <= '0;
            y <= '0;
            phase <= 1'b0;
          end
        S_ACTIVE:
          if (vs_on) begin
            state <= S_VBLANK;
            frame_done <= 1'b1;
            frame_cnt <= frame_cnt + 8'd1;
          end else if (cap) begin
            phase <= ~phase;
            if (!phase) hi <= d_q;
            else if (x <= H_MAX) x <= x + XCW'(1);
          end else if (line_end) begin
            x <= '0;
            phase <= 1'b0;
            if (y < Y_MAX) y <= y + YCW'(1);
          end
        default: state <= S_IDLE;
      endcase
    end
  // single-entry output register and sticky error flags where a set beats a clear
  always_ff @(posedge clk)
    if (reset) begin
      pix_valid <= 1'b0;
      pix_data <= '0;
      pix_x <= '0;
      pix_y <= '0;
      pix_sof <= 1'b0;
      pix_eol <= 1'b0;
      overflow <= 1'b0;
      line_err <= 1'b0;
    end else begin
      if (load) begin
        pix_valid <= 1'b1;
        pix_data <= {hi, d_q};
        pix_x <= XW'(x);
        pix_y <= YW'(y);
        pix_sof <= x == '0 && y == '0;
        pix_eol <= x == H_LAST;
      end else if (pix_ready) pix_valid <= 1'b0;
      overflow <= ov_set || (overflow && !clear_err);
      line_err <= le_set || (line_err && !clear_err);
    end
endmodule

// File: tb/tb_cam_dvp_capture.sv
// tb_cam_dvp_capture: directed frames through a 4x2 capture with hand-computed pixel expectations
module tb_cam_dvp_capture;
  logic clk = 1'b0, reset, enable, clear_err, cam_pclk, cam_href, cam_vsync, pix_ready;
  logic [7:0] cam_d;
  logic [15:0] pix_data;
  logic pix_valid, pix_sof, pix_eol, frame_done, overflow, line_err;
  logic [1:0] pix_x;
  logic [0:0] pix_y;
  logic [7:0] frame_cnt;
  int checks = 0, errors = 0, fd_cnt = 0;
  logic [31:0] pq [$];
  logic hold = 1'b0;
  logic [15:0] held;

  cam_dvp_capture #(.H_ACTIVE(4), .V_ACTIVE(2), .SYNC_STAGES(2), .VSYNC_POL(1'b1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear_err(clear_err),
    .cam_pclk(cam_pclk), .cam_href(cam_href), .cam_vsync(cam_vsync), .cam_d(cam_d),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_sof(pix_sof), .pix_eol(pix_eol),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .overflow(overflow), .line_err(line_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pk(input logic [15:0] d, input int x, input int y, input bit s, input bit e);
    return {11'b0, e, s, 1'(y), 2'(x), d};
  endfunction

  always @(posedge clk)
    if (reset) hold = 1'b0;
    else begin
      if (hold) chk("hold_stable", {15'b0, pix_valid, pix_data}, {15'b0, 1'b1, held});
      if (pix_valid && pix_ready) pq.push_back({11'b0, pix_eol, pix_sof, pix_y, pix_x, pix_data});
      if (frame_done) fd_cnt++;
      hold = pix_valid && !pix_ready;
      held = pix_data;
    end

  task automatic pc(input logic [7:0] d, input logic h);
    cam_d = d;
    cam_href = h;
    cam_pclk = 1'b0;
    repeat (2) @(negedge clk);
    cam_pclk = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) pc(base + 8'(i * 'h22), 1'b1);
  endtask

  task automatic gap();
    repeat (2) pc(8'h00, 1'b0);
  endtask

  task automatic vsync_pulse();
    cam_vsync = 1'b1;
    repeat (2) pc(8'h00, 1'b0);
    cam_vsync = 1'b0;
    repeat (2) pc(8'h00, 1'b0);
  endtask

  task automatic clr();
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; clear_err = 1'b0; pix_ready = 1'b1;
    cam_pclk = 1'b0; cam_href = 1'b0; cam_vsync = 1'b0; cam_d = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_valid", pix_valid, 0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_flags", {overflow, line_err, frame_done}, 0);
    reset = 1'b0;
    // enable low at power-up, raised mid-frame
    vsync_pulse();
    send(8'h12, 4);
    enable = 1'b1;
    send(8'h56, 4);
    gap();
    send(8'h12, 8);
    gap();
    chk("gate_nopix", pq.size(), 0);
    chk("gate_nodone", fd_cnt, 0);
    // nominal frame
    vsync_pulse();
    send(8'h12, 8); gap();
    send(8'h12, 8); gap();
    vsync_pulse();
    chk("nom_count", pq.size(), 8);
    chk("nom_p0", pq[0], pk(16'h1234, 0, 0, 1, 0));
    chk("nom_p1", pq[1], pk(16'h5678, 1, 0, 0, 0));
    chk("nom_p3", pq[3], pk(16'hde00, 3, 0, 0, 1));
    chk("nom_p4", pq[4], pk(16'h1234, 0, 1, 0, 0));
    chk("nom_p7", pq[7], pk(16'hde00, 3, 1, 0, 1));
    chk("nom_done", fd_cnt, 1);
    chk("nom_cnt", frame_cnt, 1);
    chk("nom_err", {overflow, line_err}, 0);
    // backpressure mid-line
    pq.delete();
    send(8'h12, 3);
    pix_ready = 1'b0;
    send(8'h78, 5);
    pc(8'h00, 1'b0);
    chk("bp_valid", pix_valid, 1);
    chk("bp_data", pix_data, 16'h5678);
    chk("bp_xy", {pix_y, pix_x}, 3'b001);
    chk("bp_ovf", overflow, 1);
    pix_ready = 1'b1;
    pc(8'h00, 1'b0);
    clr();
    chk("bp_clr", overflow, 0);
    send(8'h01, 8); gap();
    vsync_pulse();
    chk("bp_count", pq.size(), 6);
    chk("bp_p0", pq[0], pk(16'h1234, 0, 0, 1, 0));
    chk("bp_p1", pq[1], pk(16'h5678, 1, 0, 0, 0));
    chk("bp_p2", pq[2], pk(16'h0123, 0, 1, 0, 0));
    chk("bp_p5", pq[5], pk(16'hcdef, 3, 1, 0, 1));
    chk("bp_cnt", frame_cnt, 2);
    chk("bp_lerr", line_err, 0);
    // short line
    pq.delete();
    send(8'h12, 6); gap();
    chk("short_lerr", line_err, 1);
    send(8'h01, 8); gap();
    vsync_pulse();
    chk("short_count", pq.size(), 7);
    chk("short_p2", pq[2], pk(16'h9abc, 2, 0, 0, 0));
    chk("short_p3", pq[3], pk(16'h0123, 0, 1, 0, 0));
    chk("short_cnt", frame_cnt, 3);
    clr();
    chk("short_clr", line_err, 0);
    // odd byte count
    pq.delete();
    send(8'h12, 7); gap();
    chk("odd_lerr", line_err, 1);
    send(8'h01, 8); gap();
    vsync_pulse();
    chk("odd_count", pq.size(), 7);
    chk("odd_p3", pq[3], pk(16'h0123, 0, 1, 0, 0));
    chk("odd_cnt", frame_cnt, 4);
    // reset during the second pixel
    send(8'h12, 3);
    cam_d = 8'h78; cam_href = 1'b1; cam_pclk = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_valid", pix_valid, 0);
    chk("mid_data", pix_data, 0);
    chk("mid_cnt", frame_cnt, 0);
    chk("mid_flags", {overflow, line_err, frame_done}, 0);
    pq.delete();
    cam_pclk = 1'b1;
    repeat (2) @(negedge clk);
    send(8'h9a, 4); gap();
    send(8'h12, 8); gap();
    chk("mid_nopix", pq.size(), 0);
    vsync_pulse();
    send(8'h12, 8); gap();
    send(8'h01, 8); gap();
    vsync_pulse();
    chk("mid_count", pq.size(), 8);
    chk("mid_p0", pq[0], pk(16'h1234, 0, 0, 1, 0));
    chk("mid_p4", pq[4], pk(16'h0123, 0, 1, 0, 0));
    chk("mid_fcnt", frame_cnt, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cam_dvp_capture.md
Name: cam_dvp_capture

Overview:
- Camera-side capture stage placed directly downstream of the camera I2C configuration block.
- Samples the 8-bit DVP bus of the configured OV7670-class sensor (PCLK/HREF/VSYNC/D on GPIO_0) on the single system clock.
- Pairs bytes into RGB565 pixels and emits them as a valid/ready stream with x/y coordinates, frame markers and error flags.
- The downstream frame buffer feeding the HDMI output consumes this stream.

Parameters:
- H_ACTIVE, 640: pixels per line.
- V_ACTIVE, 480: lines per frame.
- SYNC_STAGES, 2: synchronizer depth on all cam_* inputs; legal range 2..3.
- VSYNC_POL, 1: 1 = cam_vsync active-high, 0 = active-low.

Ports:
- clk  in  1  system clock; must be at least 3x the cam_pclk frequency.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  capture enable; sampled at frame boundaries only.
- clear_err  in  1  one-cycle pulse that clears the sticky error flags.
- cam_pclk  in  1  camera pixel clock, treated as data.
- cam_href  in  1  line valid.
- cam_vsync  in  1  frame sync.
- cam_d  in  8  camera data.
- pix_data  out  16  RGB565 pixel: {first byte, second byte}.
- pix_valid  out  1  pixel available.
- pix_ready  in  1  downstream accepts; transfer occurs when valid and ready are both high.
- pix_x  out  $clog2(H_ACTIVE)  column of pix_data.
- pix_y  out  $clog2(V_ACTIVE)  row of pix_data.
- pix_sof  out  1  high with the pixel at (0,0).
- pix_eol  out  1  high with the pixel at x = H_ACTIVE-1.
- frame_done  out  1  one-cycle pulse at end of a captured frame.
- frame_cnt  out  8  count of completed frames; wraps 255 -> 0.
- overflow  out  1  sticky: a pixel was dropped because the output register was full.
- line_err  out  1  sticky: line length or byte-count mismatch.

Behaviour:
- Reset: all outputs are 0, FSM in S_IDLE, byte phase 0, counters 0.
- Input path: cam_pclk/href/vsync/d pass through SYNC_STAGES flops, then one further register. A pclk rising edge is detected as sync=1 and previous=0 in cycle N. The data, href and vsync used are the synchronized values in cycle N.
- FSM states:
  - S_IDLE: waits for enable=1, then goes to S_SYNC.
  - S_SYNC: waits for vsync active, then goes to S_VBLANK. Starting in S_SYNC discards any partial frame.
  - S_VBLANK: waits for vsync inactive. If enable=1, goes to S_ACTIVE with y=0; otherwise goes to S_IDLE.
  - S_ACTIVE: captures data. When vsync goes active: pulse frame_done, increment frame_cnt, go to S_VBLANK.
- Byte pairing, in S_ACTIVE with href=1 on each detected pclk edge:
  - phase 0: latch hi byte, set phase 1.
  - phase 1: form {hi, d}, set phase 0, increment x.
- Output timing: the pixel from the edge in cycle N appears with pix_valid=1 in cycle N+1. pix_x, pix_y, pix_sof and pix_eol are aligned with pix_data and are held stable while valid=1 and ready=0.
- Output register is single-entry:
  - If a new pixel completes while valid=1 and ready=0, the new pixel is dropped, the held pixel is kept, and overflow is set.
  - A new pixel completing in the same cycle as a transfer is accepted without a bubble.
- Line end (href falling):
  - If x != H_ACTIVE or phase == 1, set line_err.
  - Then x <= 0, phase <= 0, y <= y+1.
  - Pixels with x >= H_ACTIVE are not emitted. Lines with y >= V_ACTIVE are not emitted and do not set line_err.
- Frame end: vsync going active while href=1 ends the frame. The partial line is discarded and line_err is set.
- Sticky flags: clear_err clears overflow and line_err. If a set event occurs in the same cycle as clear_err, the set wins.
- enable deasserting mid-frame: the current frame completes normally, then the FSM enters S_IDLE at the next S_VBLANK exit.
- reset mid-frame: the output is immediately invalid. The FSM resumes at S_IDLE and waits for a full vsync cycle before capturing again.

Decomposition:
- Package cam_pkg holds:
  - FSM state enum: S_IDLE, S_SYNC, S_VBLANK, S_ACTIVE.
  - Default H_ACTIVE and V_ACTIVE.
  - RGB565 field widths.
- One sub-module, cam_sync_edge: parameterized-depth synchronizer plus rising/falling edge detector. It is instantiated for pclk, href and vsync; a data-only variant is used for cam_d.

Test Plan:
- Nominal frame: H_ACTIVE=4, V_ACTIVE=2, pclk = clk/4, bytes 0x12,0x34,... per line, ready=1.
  - Required: 8 pixels, first 0x1234 at (0,0) with pix_sof=1.
  - pix_eol=1 at x=3.
  - frame_done=1 for 1 cycle; frame_cnt=1; no errors.
- Backpressure: ready=0 for 3 pixel periods mid-line.
  - Required: the first held pixel is kept stable; the next pixels are dropped; overflow=1.
  - After clear_err, overflow=0.
- Short line: href drops after 3 pixels with H_ACTIVE=4.
  - Required: line_err=1; the next line starts at x=0 with y incremented.
- Odd byte count: 7 bytes in a line.
  - Required: line_err=1; the next line's first pixel is formed from its own first two bytes.
- Enable gating: enable=0 at power-up, raised mid-frame.
  - Required: no pix_valid until after the next vsync active-then-inactive sequence; first pixel at (0,0).
- Reset mid-line: assert reset for 1 cycle during pixel 2.
  - Required: all outputs 0 next cycle; no pixels until a full vsync cycle; frame_cnt=0.
